// File: rtl/i2s_multi_rx_frontend_pkg.sv
// anc_cfg_pkg: shared constants for the ANC I2S capture front-end.
//   - Serial config layout: cfg = {half_per[DIV_W-1:0], ch_en[NUM_CH-1:0]},
//     loaded LSB first (ch_en bit 0 arrives first).
//   - Slot-index constants for the left-justified I2S capture window.
//   - Front-end sequencing states.
package anc_cfg_pkg;

  // Defaults matching the standard four-mic build.
  localparam int unsigned CFG_NUM_CH_DEF = 4;
  localparam int unsigned CFG_DIV_W_DEF  = 8;

  // Field offsets inside the config word.
  localparam int unsigned CFG_EN_LSB = 0;
  localparam int unsigned CFG_LEN    = CFG_DIV_W_DEF + CFG_NUM_CH_DEF;

  // Slot index 0 is the I2S one-bit delay; data starts at index 1.
  localparam int unsigned I2S_DELAY_BIT = 0;

  function automatic int unsigned cfg_len(input int unsigned div_w,
                                          input int unsigned num_ch);
    return div_w + num_ch;
  endfunction

  function automatic int unsigned cfg_hp_lsb(input int unsigned num_ch);
    return CFG_EN_LSB + num_ch;
  endfunction

  typedef enum logic {
    ST_LOAD = 1'b0,  // shifting config bits in from cfg_in
    ST_RUN  = 1'b1   // config frozen, clocks and capture running
  } fe_state_t;

endpackage

// File: rtl/i2s_multi_rx_frontend_deser.sv
// i2s_slot_deser: per-channel MSB-first shift register for one I2S slot.
//   clk, rst_n : system clock, async active-low reset
//   shift_en   : one-clk strobe on each captured data bit
//   sd         : serial data bit of this channel
//   en         : channel enable; a disabled channel holds 0
//   sample     : assembled sample, last-shifted bit in LSB
module i2s_slot_deser
  import anc_cfg_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                shift_en,
  input  logic                sd,
  input  logic                en,
  output logic [SAMPLE_W-1:0] sample
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample <= '0;
    end else if (!en) begin
      sample <= '0;
    end else if (shift_en) begin
      sample <= {sample[SAMPLE_W-2:0], sd};
    end
  end

endmodule

// File: rtl/i2s_multi_rx_frontend.sv
// i2s_multi_rx_frontend: N-channel I2S capture front-end.
//   clk, rst_n   : system clock, async active-low reset
//   cfg_in       : serial config bit, one per clk after reset
//   cfg_done     : config loaded, capture running
//   sck, ws      : generated I2S bit clock / word select (ws=0 captured)
//   sd           : serial data, bit i = channel i
//   dout         : frame, ch i at [i*SAMPLE_W +: SAMPLE_W]
//   dout_vld/rdy : frame handshake toward the controller
//   ch_en        : decoded channel-enable mask
//   overrun      : sticky, a valid frame was overwritten unread
//   overrun_clr  : synchronous clear of overrun
module i2s_multi_rx_frontend
  import anc_cfg_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned SLOT_W   = 32,
  parameter int unsigned DIV_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_in,
  output logic                       cfg_done,
  output logic                       sck,
  output logic                       ws,
  input  logic [NUM_CH-1:0]          sd,
  output logic [NUM_CH*SAMPLE_W-1:0] dout,
  output logic                       dout_vld,
  input  logic                       dout_rdy,
  output logic [NUM_CH-1:0]          ch_en,
  output logic                       overrun,
  input  logic                       overrun_clr
);

  localparam int unsigned CLEN = cfg_len(DIV_W, NUM_CH);
  localparam int unsigned LCW  = $clog2(CLEN + 1);
  localparam int unsigned BCW  = $clog2(2 * SLOT_W);

  fe_state_t state, state_nxt;

  logic [CLEN-1:0]            cfg;
  logic [LCW-1:0]             load_cnt;
  logic [DIV_W-1:0]           half_per, hp, div_cnt;
  logic [BCW-1:0]             bit_cnt;
  logic                       run, toggle, rise, fall, left, shift_en, frame_rdy;
  logic                       ovr_set;
  logic [NUM_CH*SAMPLE_W-1:0] sh_all;

  assign run      = (state == ST_RUN);
  assign cfg_done = run;
  assign half_per = cfg[cfg_hp_lsb(NUM_CH) +: DIV_W];
  assign ch_en    = run ? cfg[CFG_EN_LSB +: NUM_CH] : '0;

  // Sequencing FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD: if (load_cnt == LCW'(CLEN - 1)) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg      <= '0;
      load_cnt <= '0;
    end else if (!run) begin
      cfg      <= {cfg_in, cfg[CLEN-1:1]};
      load_cnt <= load_cnt + LCW'(1);
    end
  end

  // Clock generation: a zero half-period would never toggle, so clamp to 1.
  assign hp     = (half_per == '0) ? DIV_W'(1) : half_per;
  assign toggle = run && (div_cnt == hp - DIV_W'(1));
  assign rise   = toggle && !sck;
  assign fall   = toggle && sck;
  assign ws     = (bit_cnt >= BCW'(SLOT_W));
  assign left   = !ws;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sck     <= 1'b0;
      bit_cnt <= '0;
    end else if (run) begin
      div_cnt <= toggle ? '0 : div_cnt + DIV_W'(1);
      if (toggle) sck <= ~sck;
      if (fall) begin
        bit_cnt <= (bit_cnt == BCW'(2 * SLOT_W - 1)) ? '0 : bit_cnt + BCW'(1);
      end
    end
  end

  // Capture window: left slot, indices 1..SAMPLE_W (index 0 is the delay bit).
  assign shift_en = rise && left && (bit_cnt != BCW'(I2S_DELAY_BIT))
                    && (bit_cnt <= BCW'(SAMPLE_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_rdy <= 1'b0;
    else        frame_rdy <= rise && left && (bit_cnt == BCW'(SAMPLE_W));
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    i2s_slot_deser #(.SAMPLE_W(SAMPLE_W)) u_deser (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (shift_en),
      .sd       (sd[i]),
      .en       (ch_en[i]),
      .sample   (sh_all[i*SAMPLE_W +: SAMPLE_W])
    );
  end

  // Output holding register: a new frame always loads (newest wins); a
  // coincident accept keeps dout_vld high and suppresses the overrun.
  assign ovr_set = frame_rdy && dout_vld && !dout_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout     <= '0;
      dout_vld <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (frame_rdy) begin
        dout     <= sh_all;
        dout_vld <= 1'b1;
      end else if (dout_vld && dout_rdy) begin
        dout_vld <= 1'b0;
      end
      if (ovr_set)          overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_multi_rx_frontend.sv
// Self-checking bench for i2s_multi_rx_frontend: an I2S microphone model
// follows the generated sck/ws and transmits known or random words; the
// expected frame is the transmitted word masked by the configured enables.
module tb_i2s_multi_rx_frontend;

  localparam int NUM_CH   = 4;
  localparam int SAMPLE_W = 16;
  localparam int SLOT_W   = 32;
  localparam int DIV_W    = 8;
  localparam int FW       = NUM_CH * SAMPLE_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_in = 1'b0;
  logic              cfg_done, sck, ws;
  logic [NUM_CH-1:0] sd = '0;
  logic [FW-1:0]     dout;
  logic              dout_vld;
  logic              dout_rdy = 1'b0;
  logic [NUM_CH-1:0] ch_en;
  logic              overrun;
  logic              overrun_clr = 1'b0;

  always #5 clk = ~clk;

  i2s_multi_rx_frontend #(
    .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .SLOT_W(SLOT_W), .DIV_W(DIV_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_in(cfg_in), .cfg_done(cfg_done),
    .sck(sck), .ws(ws), .sd(sd), .dout(dout), .dout_vld(dout_vld),
    .dout_rdy(dout_rdy), .ch_en(ch_en), .overrun(overrun),
    .overrun_clr(overrun_clr)
  );

  int errors = 0;
  int checks = 0;

  int                pat_mode = 0;
  logic [NUM_CH-1:0] cur_en = '0;
  int                fcnt = 0;     // slot position seen by the mic model
  int                cap_cnt = 0;  // count of final-data-bit sampling edges
  logic              prev_sck = 1'b0;
  logic [FW-1:0]     tx_word;

  function automatic logic [FW-1:0] gen_word();
    if (pat_mode == 0) return {16'hFFFF, 16'h1234, 16'h7FFF, 16'h8001};
    return {$urandom, $urandom};
  endfunction

  function automatic logic [FW-1:0] exp_frame();
    logic [FW-1:0] r = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (cur_en[i]) r[i*SAMPLE_W +: SAMPLE_W] = tx_word[i*SAMPLE_W +: SAMPLE_W];
    return r;
  endfunction

  // Mic model: new word per ws period, MSB in slot position 1, random
  // garbage on the delay bit and the whole right slot.
  initial begin
    tx_word = gen_word();
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        fcnt     = 0;
        prev_sck = 1'b0;
        tx_word  = gen_word();
      end else begin
        if (prev_sck && !sck) begin
          fcnt = (fcnt + 1) % (2 * SLOT_W);
          if (fcnt == 0) tx_word = gen_word();
        end
        if (!prev_sck && sck && fcnt == SAMPLE_W) cap_cnt++;
        prev_sck = sck;
      end
      for (int i = 0; i < NUM_CH; i++)
        sd[i] = (fcnt >= 1 && fcnt <= SAMPLE_W) ? tx_word[i*SAMPLE_W + SAMPLE_W - fcnt]
                                                : 1'($urandom);
    end
  end

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_cfg(input logic [DIV_W-1:0] hp, input logic [NUM_CH-1:0] en, input int mode);
    logic [DIV_W+NUM_CH-1:0] w;
    w = {hp, en};
    pat_mode = mode;
    cur_en = en;
    rst_n = 1'b0; cfg_in = 1'b0; dout_rdy = 1'b0; overrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < DIV_W + NUM_CH; j++) begin
      cfg_in = w[j];
      @(negedge clk);
      if (j == DIV_W + NUM_CH - 2) check("cfg_done_early", FW'(cfg_done), FW'(0));
    end
    check("cfg_done", FW'(cfg_done), FW'(1));
    check("ch_en", FW'(ch_en), FW'(en));
  endtask

  task automatic wait_vld(input string tag);
    int n = 0;
    while (dout_vld !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, FW'(dout_vld), FW'(1));
  endtask

  // Clocks between consecutive rising edges of sck (use_ws=0) or ws.
  task automatic measure(input bit use_ws, output int n);
    logic prev, cur;
    int t = 0;
    n = 0;
    prev = use_ws ? ws : sck;
    cur = prev;
    while (t < 3000) begin
      @(negedge clk); t++;
      cur = use_ws ? ws : sck;
      if (cur && !prev) break;
      prev = cur;
    end
    prev = cur;
    while (t < 3000) begin
      @(negedge clk); t++; n++;
      cur = use_ws ? ws : sck;
      if (cur && !prev) break;
      prev = cur;
    end
  endtask

  initial begin
    int n;
    int c;
    logic [FW-1:0] held;

    // Reset state
    @(negedge clk);
    check("rst_dout", dout, FW'(0));
    check("rst_ctl", FW'({cfg_done, sck, ws, dout_vld, overrun, ch_en}), FW'(0));

    // Config load, hp=2, all channels, fixed patterns
    load_cfg(8'd2, 4'b1111, 0);
    dout_rdy = 1'b1;
    measure(1'b0, n);
    check("sck_period", FW'(n), FW'(4));
    measure(1'b1, n);
    check("ws_period", FW'(n), FW'(2 * SLOT_W * 4));

    // Capture with fixed words
    for (int f = 0; f < 3; f++) begin
      wait_vld("cap_wait");
      check("cap_dout", dout, exp_frame());
      @(negedge clk);
      check("cap_pulse", FW'(dout_vld), FW'(0));
    end

    // Masking, random words, hp=1
    load_cfg(8'd1, 4'b0101, 1);
    dout_rdy = 1'b1;
    for (int f = 0; f < 2; f++) begin
      wait_vld("mask_wait");
      check("mask_dout", dout, exp_frame());
      check("mask_off_ch", FW'({dout[31:16], dout[63:48]}), FW'(0));
      @(negedge clk);
    end

    // Backpressure over two frames
    dout_rdy = 1'b0;
    wait_vld("bp_first");
    check("bp_first_dout", dout, exp_frame());
    n = 0;
    while (overrun !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("bp_overrun", FW'(overrun), FW'(1));
    check("bp_vld", FW'(dout_vld), FW'(1));
    check("bp_newest", dout, exp_frame());
    held = exp_frame();
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("ovr_clear", FW'(overrun), FW'(0));
    check("ovr_clear_vld", FW'(dout_vld), FW'(1));
    dout_rdy = 1'b1;
    @(negedge clk);
    dout_rdy = 1'b0;
    check("drain_vld", FW'(dout_vld), FW'(0));
    check("drain_hold", dout, held);

    // Accept coinciding with a new frame
    wait_vld("coin_first");
    c = cap_cnt;
    n = 0;
    while (cap_cnt == c && n < 3000) begin
      @(negedge clk);
      n++;
    end
    dout_rdy = 1'b1;
    @(negedge clk);
    dout_rdy = 1'b0;
    check("coin_vld", FW'(dout_vld), FW'(1));
    check("coin_dout", dout, exp_frame());
    check("coin_overrun", FW'(overrun), FW'(0));
    held = exp_frame();
    repeat (5) @(negedge clk);
    check("coin_stable", dout, held);

    // Reset mid-frame at slot position 20, reload with half_per=0
    n = 0;
    while (fcnt != 20 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("mid_pos", FW'(fcnt), FW'(20));
    rst_n = 1'b0;
    #1;
    check("mid_rst_dout", dout, FW'(0));
    check("mid_rst_ctl", FW'({cfg_done, sck, ws, dout_vld, overrun, ch_en}), FW'(0));
    @(negedge clk);
    load_cfg(8'd0, 4'b1111, 1);
    dout_rdy = 1'b1;
    measure(1'b0, n);
    check("hp0_sck_period", FW'(n), FW'(2));
    wait_vld("hp0_wait");
    check("hp0_dout", dout, exp_frame());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
